fifo_rr_arbiter: RTL

- Controller that shares one downstream FIFO write port among NUM_LANES upstream FIFOs.
- Configures every upstream FIFO's high_limit/low_limit thresholds during an INIT phase.
- Pops one upstream lane per cycle in round-robin order, pushes the word downstream, and pauses on downstream almost-full.
- Sits between the upstream FIFO bank and the shared downstream FIFO; owns all fifo_read strobes.

---
 rtl/fifo_rr_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: shares one downstream FIFO write port among NUM_LANES upstream FIFOs.
// Optional macro ARB_PRIO_EN gives lane 0 strict priority over the round-robin lanes.
module fifo_rr_arbiter #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3,
    parameter int NUM_LANES = 4,
    parameter int HIGH      = 6,
    parameter int LOW       = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic [ADDR_BITS-1:0]           high_limit_in,
    input  logic [ADDR_BITS-1:0]           low_limit_in,
    input  logic [NUM_LANES-1:0]           fifo_empty,
    input  logic [NUM_LANES-1:0]           fifo_error,
    input  logic [NUM_LANES*DATA_BITS-1:0] fifo_data,
    input  logic                           down_almost_full,
    output logic [NUM_LANES-1:0]           fifo_read,
    output logic [ADDR_BITS-1:0]           high_limit,
    output logic [ADDR_BITS-1:0]           low_limit,
    output logic [DATA_BITS-1:0]           data_out,
    output logic                           push_out,
    output logic [2:0]                     state,
    output logic                           idle_out,
    output logic                           error_out
);

    localparam int PTR_BITS = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1;
    localparam logic [NUM_LANES-1:0] LANE_ONE = NUM_LANES'(1);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t              st;
    logic [PTR_BITS-1:0] ptr;
    logic [PTR_BITS-1:0] gnt_lane;
    logic [PTR_BITS-1:0] rd_lane;
    logic                rd_valid;
    logic                found;
    logic [PTR_BITS-1:0] pick;
    logic [PTR_BITS-1:0] idx;
    logic                any_err;
    logic                any_ready;
`ifdef ARB_PRIO_EN
    logic                prio_hit;
`endif

    assign state     = st;
    assign any_err   = |fifo_error;
    assign any_ready = ~&fifo_empty;

    // First non-empty lane after the last granted one, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
`ifdef ARB_PRIO_EN
        prio_hit = 1'b0;
        if (!fifo_empty[0]) begin
            found    = 1'b1;
            prio_hit = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = PTR_BITS'((32'(ptr) + 32'(k)) % NUM_LANES);
            if (!found && !fifo_empty[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_RESET;
            ptr        <= PTR_BITS'(NUM_LANES - 1);
            gnt_lane   <= '0;
            rd_lane    <= '0;
            rd_valid   <= 1'b0;
            fifo_read  <= '0;
            high_limit <= ADDR_BITS'(HIGH);
            low_limit  <= ADDR_BITS'(LOW);
            data_out   <= '0;
            push_out   <= 1'b0;
            idle_out   <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            // Words already popped always complete, whatever the state does.
            rd_valid  <= |fifo_read;
            rd_lane   <= gnt_lane;
            push_out  <= rd_valid;
            if (rd_valid)
                data_out <= fifo_data[32'(rd_lane)*DATA_BITS +: DATA_BITS];
            fifo_read <= '0;
            idle_out  <= 1'b0;

            if (st == S_RESET) begin
                st <= S_INIT;
            end else if (any_err || st == S_ERROR) begin
                st        <= S_ERROR;
                error_out <= 1'b1;
            end else if (init) begin
                st <= S_INIT;
                if (st == S_INIT) begin
                    high_limit <= high_limit_in;
                    low_limit  <= low_limit_in;
                end
            end else begin
                unique case (st)
                    S_INIT: begin
                        st         <= S_IDLE;
                        idle_out   <= 1'b1;
                        high_limit <= high_limit_in;
                        low_limit  <= low_limit_in;
                    end
                    S_IDLE: begin
                        if (any_ready)
                            st <= S_ACTIVE;
                        else
                            idle_out <= 1'b1;
                    end
                    S_ACTIVE: begin
                        if (!any_ready) begin
                            st       <= S_IDLE;
                            idle_out <= 1'b1;
                        end else if (!down_almost_full && found) begin
                            fifo_read <= LANE_ONE << pick;
                            gnt_lane  <= pick;
`ifdef ARB_PRIO_EN
                            if (!prio_hit)
                                ptr <= pick;
`else
                            ptr <= pick;
`endif
                        end
                    end
                    default: begin
                        st <= S_ERROR;
                    end
                endcase
            end
        end
    end

endmodule
